// File: rtl/mac_result_serializer_if.sv
// -----------------------------------------------------------------------------
// mac_result_serializer_if
//   Handshake bundle between the MAC result storage, the bit-serial readout
//   stage and the downstream pad driver.
//
//   Load side (upstream -> serializer):
//     load_valid  parallel word present on d_in
//     load_ready  serializer can take a parallel word this cycle
//     d_in        parallel accumulator result, WIDTH bits
//   Serial side (serializer -> downstream):
//     tx_bit      current serial bit, MSB first
//     tx_valid    tx_bit is valid
//     tx_ready    downstream accepts tx_bit this cycle
//     tx_last     tx_bit is bit 0 of the word
//     busy        a word is in flight (same as tx_valid)
//
//   modport slave  : the serializer itself
//   modport master : whoever drives loads and consumes bits (the environment)
// -----------------------------------------------------------------------------
interface mac_result_serializer_if #(
    parameter int WIDTH = 16
);
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] d_in;
    logic             tx_bit;
    logic             tx_valid;
    logic             tx_ready;
    logic             tx_last;
    logic             busy;

    modport slave (
        input  load_valid,
        input  d_in,
        input  tx_ready,
        output load_ready,
        output tx_bit,
        output tx_valid,
        output tx_last,
        output busy
    );

    modport master (
        output load_valid,
        output d_in,
        output tx_ready,
        input  load_ready,
        input  tx_bit,
        input  tx_valid,
        input  tx_last,
        input  busy
    );
endinterface

// File: rtl/mac_result_serializer.sv
// -----------------------------------------------------------------------------
// mac_result_serializer
//   Bit-serial readout stage for the MAC unit. Captures a parallel accumulator
//   result in one cycle and shifts it out MSB-first, one bit per accepted
//   valid/ready transfer. A new word may be loaded on the edge that transfers
//   the last bit of the current word, giving gap-free back-to-back streaming.
//
//   Parameters:
//     WIDTH   result width in bits (2..32); must match the interface WIDTH
//   Ports:
//     clk     system clock, rising edge
//     r       asynchronous active-low reset
//     bus     mac_result_serializer_if.slave handshake bundle
//
//   All outputs except load_ready decode straight from flops; load_ready has a
//   combinational path from tx_ready so a reload can land on the last-bit edge.
// -----------------------------------------------------------------------------
module mac_result_serializer #(
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     r,
    mac_result_serializer_if.slave   bus
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic tx_valid_w;
    logic tx_last_w;
    logic load_ready_w;
    logic load_acc;
    logic tx_acc;

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    assign tx_valid_w   = (state_q == SHIFT);
    assign tx_last_w    = tx_valid_w && (cnt_q == LAST_CNT);
    // Ready either when empty, or when the final bit leaves on this edge.
    assign load_ready_w = (state_q == IDLE) || (tx_last_w && bus.tx_ready);

    assign load_acc = bus.load_valid && load_ready_w;
    assign tx_acc   = tx_valid_w && bus.tx_ready;

    assign bus.tx_bit     = sr_q[WIDTH-1];
    assign bus.tx_valid   = tx_valid_w;
    assign bus.busy       = tx_valid_w;
    assign bus.tx_last    = tx_last_w;
    assign bus.load_ready = load_ready_w;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;

        if (load_acc) begin
            // A load on the last-bit edge overrides the drain to IDLE.
            sr_d    = bus.d_in;
            cnt_d   = '0;
            state_d = SHIFT;
        end else if (tx_acc) begin
            if (tx_last_w) begin
                sr_d    = '0;
                cnt_d   = '0;
                state_d = IDLE;
            end else begin
                sr_d  = {sr_q[WIDTH-2:0], 1'b0};
                cnt_d = cnt_q + 1'b1;
            end
        end
        // Otherwise idle or stalled: everything holds.
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mac_result_serializer.sv
// -----------------------------------------------------------------------------
// tb_mac_result_serializer
//   Directed bench for mac_result_serializer (WIDTH = 16). Every accepted load
//   pushes its bits MSB-first into an expected queue; every serial transfer is
//   compared against the queue head. Inputs change on the falling edge and
//   outputs are sampled 1 ns later, well away from the rising edge.
// -----------------------------------------------------------------------------
module tb_mac_result_serializer;

    localparam int W = 16;

    typedef struct packed {
        logic b;
        logic l;
    } exp_t;

    logic clk = 1'b0;
    logic r   = 1'b0;

    mac_result_serializer_if #(.WIDTH(W)) bus ();

    mac_result_serializer #(.WIDTH(W)) dut (
        .clk (clk),
        .r   (r),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    exp_t        q[$];
    int          checks    = 0;
    int          errors    = 0;
    int          vcount    = 0;
    int          last_cnt  = 0;
    logic        load_acc  = 1'b0;
    logic [31:0] rx_word   = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        vcount   = 0;
        last_cnt = 0;
        rx_word  = '0;
    endtask

    // One clock cycle: drive inputs (we are at a falling edge), let them
    // settle, compare outputs against the model, then advance to the next
    // falling edge (passing through the rising edge that acts on them).
    task automatic cyc(input logic lv, input logic [W-1:0] d, input logic rdy);
        exp_t e;
        logic exp_valid;
        logic exp_ready;
        bus.load_valid = lv;
        bus.d_in       = d;
        bus.tx_ready   = rdy;
        #1;
        exp_valid = (q.size() != 0);
        exp_ready = (q.size() == 0) || (q.size() == 1 && rdy);
        chk("tx_valid", bus.tx_valid, exp_valid);
        chk("busy", bus.busy, exp_valid);
        chk("load_ready", bus.load_ready, exp_ready);
        if (exp_valid) begin
            // Held bits during a stall are compared against the same head.
            e = q[0];
            chk("tx_bit", bus.tx_bit, e.b);
            chk("tx_last", bus.tx_last, e.l);
            if (rdy) begin
                void'(q.pop_front());
                rx_word = {rx_word[30:0], bus.tx_bit};
                if (bus.tx_last) last_cnt++;
            end
        end else begin
            chk("tx_last_idle", bus.tx_last, 1'b0);
        end
        if (bus.tx_valid) vcount++;
        load_acc = lv && exp_ready;
        if (load_acc) begin
            for (int i = W - 1; i >= 0; i--) begin
                e.b = d[i];
                e.l = (i == 0);
                q.push_back(e);
            end
        end
        @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_load_ready"}, bus.load_ready, 1'b1);
        chk({tag, "_tx_valid"}, bus.tx_valid, 1'b0);
        chk({tag, "_tx_last"}, bus.tx_last, 1'b0);
        chk({tag, "_busy"}, bus.busy, 1'b0);
        chk({tag, "_tx_bit"}, bus.tx_bit, 1'b0);
    endtask

    initial begin
        bus.load_valid = 1'b0;
        bus.d_in       = '0;
        bus.tx_ready   = 1'b0;

        // ---------------- reset ----------------
        repeat (3) @(negedge clk);
        #1;
        chk_reset_outputs("rst_held");
        @(negedge clk);
        r = 1'b1;
        #1;
        chk_reset_outputs("rst_release");
        @(negedge clk);

        // ---------------- basic stream A5C3 ----------------
        clear_stats();
        cyc(1'b1, 16'hA5C3, 1'b1);
        chk("basic_load_acc", load_acc, 1'b1);
        repeat (W) cyc(1'b0, 16'h0000, 1'b1);
        chk("basic_word", rx_word[15:0], 16'hA5C3);
        chk("basic_vcount", vcount, 16);
        chk("basic_last_cnt", last_cnt, 1);
        cyc(1'b0, 16'h0000, 1'b1);   // 17th cycle must be idle
        chk("basic_vcount_after", vcount, 16);

        // ---------------- backpressure 8001 ----------------
        clear_stats();
        cyc(1'b1, 16'h8001, 1'b1);
        cyc(1'b0, 16'h0000, 1'b1);              // bit 15 (MSB) out
        repeat (3) cyc(1'b0, 16'h0000, 1'b0);   // stall
        repeat (14) cyc(1'b0, 16'h0000, 1'b1);
        cyc(1'b0, 16'h0000, 1'b0);              // stall before last
        cyc(1'b0, 16'h0000, 1'b1);              // last bit
        cyc(1'b0, 16'h0000, 1'b1);
        chk("bp_word", rx_word[15:0], 16'h8001);
        chk("bp_vcount", vcount, 20);
        chk("bp_last_cnt", last_cnt, 1);

        // ---------------- back-to-back FFFF / 0000 ----------------
        clear_stats();
        cyc(1'b1, 16'hFFFF, 1'b1);
        for (int i = 0; i < W - 1; i++) begin
            cyc(1'b1, 16'h0000, 1'b1);
            chk("b2b_not_taken", load_acc, 1'b0);
        end
        cyc(1'b1, 16'h0000, 1'b1);              // last-bit edge
        chk("b2b_taken_on_last", load_acc, 1'b1);
        repeat (W) cyc(1'b0, 16'h0000, 1'b1);
        chk("b2b_word", rx_word, 32'hFFFF_0000);
        chk("b2b_vcount", vcount, 32);
        chk("b2b_last_cnt", last_cnt, 2);
        cyc(1'b0, 16'h0000, 1'b1);
        chk("b2b_vcount_after", vcount, 32);

        // ---------------- load while busy F0F0 / 1234 ----------------
        clear_stats();
        cyc(1'b1, 16'hF0F0, 1'b1);
        repeat (5) cyc(1'b0, 16'h5A5A, 1'b1);   // d_in noise is ignored
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 16'h1234, 1'b1);
            chk("busy_not_taken", load_acc, 1'b0);
        end
        cyc(1'b1, 16'h1234, 1'b1);
        chk("busy_taken_on_last", load_acc, 1'b1);
        repeat (W) cyc(1'b0, 16'hFFFF, 1'b1);
        chk("busy_word", rx_word, 32'hF0F0_1234);
        chk("busy_vcount", vcount, 32);
        cyc(1'b0, 16'h0000, 1'b1);

        // ---------------- reset mid-word BEEF ----------------
        clear_stats();
        cyc(1'b1, 16'hBEEF, 1'b1);
        repeat (7) cyc(1'b0, 16'h0000, 1'b1);   // bits 15..9 sent, bit 8 showing
        bus.tx_ready = 1'b0;
        #3;
        r = 1'b0;                               // between edges
        #1;
        chk_reset_outputs("rst_mid");
        q.delete();                             // partial word discarded
        @(negedge clk);
        @(negedge clk);
        chk_reset_outputs("rst_mid_held");
        r = 1'b1;
        clear_stats();
        cyc(1'b1, 16'h0F0F, 1'b1);
        chk("rst_reload_acc", load_acc, 1'b1);
        repeat (W) cyc(1'b0, 16'h0000, 1'b1);
        chk("rst_reload_word", rx_word[15:0], 16'h0F0F);
        chk("rst_reload_vcount", vcount, 16);
        cyc(1'b0, 16'h0000, 1'b1);

        chk("queue_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mac_result_serializer.md
# mac_result_serializer

Bit-serial readout stage for the MAC unit. It captures a parallel accumulator result in one clock cycle. It then shifts the result out MSB-first, one bit per accepted transfer, using a valid/ready handshake. It is the read-side counterpart of the MAC's bit-sliced result storage: that storage is written in parallel, and this block drains it serially toward the chip output pad.

## Interface
- WIDTH, 16, result width in bits; legal range 2..32.
- CLK  input  1  system clock; all state changes on the rising edge.
- R  input  1  reset, asynchronous, active-low; asserted while 0.
- LOAD_VALID  input  1  a parallel result is present on D_IN.
- LOAD_READY  output  1  the block can accept a parallel load this cycle.
- D_IN  input  WIDTH  parallel result word from the MAC accumulator.
- TX_BIT  output  1  current serial bit, MSB-first.
- TX_VALID  output  1  TX_BIT is valid.
- TX_READY  input  1  the downstream consumer accepts TX_BIT this cycle.
- TX_LAST  output  1  TX_BIT is bit 0, the final bit of the word.
- BUSY  output  1  a word is in flight; equals TX_VALID.

## Operation
- Internal state:
  - shift register SR[WIDTH-1:0];
  - bit counter CNT, width clog2(WIDTH), counting bits already sent;
  - 1-bit state, IDLE or SHIFT.
- Load is accepted when LOAD_VALID && LOAD_READY at the rising edge. On accept: SR <= D_IN, CNT <= 0, state <= SHIFT.
- Transfer is accepted when TX_VALID && TX_READY at the rising edge.
- On a transfer that is not the last bit: SR <= {SR[WIDTH-2:0], 1'b0} and CNT <= CNT+1.
- On a transfer of the last bit (CNT == WIDTH-1):
  - with no load in the same cycle, state <= IDLE and SR <= 0;
  - with a load in the same cycle, the load wins and the word streams back-to-back.
- Output decode:
  - TX_BIT = SR[WIDTH-1];
  - TX_VALID = BUSY = (state == SHIFT);
  - TX_LAST = (state == SHIFT) && (CNT == WIDTH-1);
  - LOAD_READY = (state == IDLE) || (TX_LAST && TX_READY).
- LOAD_READY is the only output with a combinational path from an input (TX_READY). All other outputs decode directly from flops.
- State transitions:
  - IDLE -> SHIFT on load;
  - SHIFT -> SHIFT on a non-last transfer, on a stall, or on last transfer plus load;
  - SHIFT -> IDLE on last transfer without a load.
- Stall: if TX_VALID && !TX_READY, SR, CNT and state hold, and TX_BIT and TX_LAST stay stable.
- LOAD_VALID while SHIFT and not on the last accepted bit: ignored, LOAD_READY = 0. The upstream must hold its data until it sees ready.
- D_IN is sampled only on the load edge, so changes at any other time have no effect.
- Reset: asserting R (low) at any time, including mid-word, forces the block asynchronously to:
  - state IDLE, SR = 0, CNT = 0;
  - TX_VALID = TX_LAST = BUSY = TX_BIT = 0, LOAD_READY = 1.
- A partially sent word is discarded. There is no resume.
- Deassertion of R is assumed synchronised upstream. The first load can be accepted on the first rising edge with R high.

## Timing
- Load-to-first-bit latency: 1 cycle. The load edge at cycle N gives TX_VALID=1 and TX_BIT = D_IN[WIDTH-1] during cycle N+1.
- With TX_READY held at 1, a word occupies exactly WIDTH cycles with TX_VALID high. TX_LAST is high in the WIDTH-th cycle only.
- Back-to-back throughput: 1 bit per cycle with no idle gap. The next word's MSB appears in the cycle after the previous word's last-bit transfer.
- Without a same-cycle reload, TX_VALID drops in the cycle after the last transfer. LOAD_READY is then 1 from IDLE.
- Each stall cycle adds exactly 1 cycle of latency. There is no bit loss and no duplication.

## Test plan
- Reset check: hold R=0, then release. Required: LOAD_READY=1 and TX_VALID=TX_LAST=BUSY=TX_BIT=0.
- Basic stream:
  - Stimulus: WIDTH=16, load D_IN=16'hA5C3, TX_READY=1.
  - Required: TX_BIT over 16 cycles = 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1; TX_LAST only on the 16th bit; TX_VALID=0 on the 17th cycle.
- Backpressure:
  - Stimulus: load 16'h8001, drop TX_READY for 3 cycles after bit 0 and for 1 cycle before the last bit.
  - Required: TX_BIT and TX_LAST are held during stalls; the received word is 16'h8001; total is 20 valid cycles.
- Back-to-back:
  - Stimulus: present load 16'hFFFF, then 16'h0000 with LOAD_VALID held high.
  - Required: the second load is accepted on the first word's last-bit edge; 32 contiguous valid bits, 16 ones then 16 zeros; TX_LAST pulses twice.
- Load while busy:
  - Stimulus: assert LOAD_VALID with 16'h1234 at bit 5 of 16'hF0F0.
  - Required: LOAD_READY=0 and 16'hF0F0 completes intact. 16'h1234 is accepted only at the last-bit edge and then streams correctly.
- Reset mid-word:
  - Stimulus: pull R low asynchronously, between clock edges, at bit 7 of 16'hBEEF.
  - Required: outputs reach their reset values without waiting for a clock edge. After release, a load of 16'h0F0F streams correctly from its MSB.
